// File: rtl/dcache_ctrl_pkg.sv
// Shared widths, state encoding and small helpers for the 2-way data-cache controller.
package dcache_ctrl_pkg;
    localparam int HIT_WIDTH       = 2;
    localparam int TAG_WIDTH       = 55;
    localparam int CACHELINE_WIDTH = 64;
    localparam int ADDR_WIDTH      = 64;
    localparam int INDEX_WIDTH     = 6;
    localparam int SETS            = 64;

    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [INDEX_WIDTH-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WB_READ     = 3'd1,
        ST_WB_SEND     = 3'd2,
        ST_REFILL_REQ  = 3'd3,
        ST_REFILL_WAIT = 3'd4,
        ST_REFILL      = 3'd5,
        ST_REPLAY      = 3'd6
    } state_t;

    function automatic logic [HIT_WIDTH-1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU, data-array and memory-side signals of the cache controller; master is the controller.
interface dcache_ctrl_if;
    import dcache_ctrl_pkg::*;

    logic                       cpu_req;
    logic                       cpu_we;
    logic [ADDR_WIDTH-1:0]      cpu_addr;
    logic                       cpu_stall;

    logic [HIT_WIDTH-1:0]       hit;
    logic                       lru;
    logic                       vaild;
    logic                       dirty;
    logic                       write_back;
    logic                       refresh;
    logic [ADDR_WIDTH-1:0]      data_addr;
    logic [CACHELINE_WIDTH-1:0] cacheline_old;
    logic [CACHELINE_WIDTH-1:0] cacheline_new;

    logic                       rd_req;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic                       rd_ready;
    logic                       rd_valid;
    logic [CACHELINE_WIDTH-1:0] rd_data;

    logic                       wr_req;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [CACHELINE_WIDTH-1:0] wr_data;
    logic                       wr_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cacheline_old, rd_ready, rd_valid, rd_data, wr_ready,
        output cpu_stall, hit, lru, vaild, dirty, write_back, refresh, data_addr, cacheline_new,
               rd_req, rd_addr, wr_req, wr_addr, wr_data
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cacheline_old, rd_ready, rd_valid, rd_data, wr_ready,
        input  cpu_stall, hit, lru, vaild, dirty, write_back, refresh, data_addr, cacheline_new,
               rd_req, rd_addr, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/dcache_tag.sv
// Tag/valid/dirty/lru store for 64 sets x 2 ways: combinational lookup, clocked update.
module dcache_tag
    import dcache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  idx_t                 i_idx,
    input  tag_t                 i_tag,
    input  logic                 i_req,
    input  logic                 i_vway,
    input  logic                 i_way,
    input  logic                 i_touch,
    input  logic                 i_store,
    input  logic                 i_fill,
    output logic [HIT_WIDTH-1:0] o_hit,
    output logic                 o_lru,
    output logic                 o_vvalid,
    output logic                 o_vdirty,
    output tag_t                 o_vtag
);
    logic [SETS-1:0][HIT_WIDTH-1:0] r_valid;
    logic [SETS-1:0][HIT_WIDTH-1:0] r_dirty;
    logic [SETS-1:0]                r_lru;
    tag_t                           r_tag [SETS][HIT_WIDTH];

    always_comb begin
        for (int w = 0; w < HIT_WIDTH; w++) begin
            o_hit[w] = i_req & r_valid[i_idx][w] & (r_tag[i_idx][w] == i_tag);
        end
    end

    assign o_lru    = r_lru[i_idx];
    assign o_vvalid = r_valid[i_idx][i_vway];
    assign o_vdirty = r_dirty[i_idx][i_vway];
    assign o_vtag   = r_tag[i_idx][i_vway];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_lru   <= '0;
        end else begin
            if (i_touch) begin
                r_lru[i_idx] <= ~i_way;
                if (i_store) r_dirty[i_idx][i_way] <= 1'b1;
            end
            if (i_fill) begin
                r_valid[i_idx][i_way] <= 1'b1;
                r_dirty[i_idx][i_way] <= 1'b0;
            end
        end
    end

    // NOTE: the tag array has no reset; a tag is only looked at behind its valid bit,
    // which is reset, so clearing 7k bits of storage would buy nothing.
    always_ff @(posedge clk) begin
        if (i_fill) r_tag[i_idx][i_way] <= i_tag;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, 2-way set-associative data-cache controller: hit path, victim write-back, refill, replay.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input logic        clk,
    input logic        rst,
    dcache_ctrl_if.master bus
);
    state_t                     r_state, w_next;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic                       r_we;
    logic                       r_victim;
    logic                       r_wb_first;
    logic [CACHELINE_WIDTH-1:0] r_wr_data;
    logic [CACHELINE_WIDTH-1:0] r_line;

    logic                 w_idle, w_req, w_miss, w_victim, w_lru, w_vvalid, w_vdirty;
    logic                 w_touch, w_way, w_fill, w_we;
    logic [HIT_WIDTH-1:0] w_hit;
    idx_t                 w_idx;
    tag_t                 w_tag, w_vtag;

    // In IDLE the live CPU address drives the lookup; afterwards the latched miss address does.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_idx    = w_idle ? bus.cpu_addr[8:3]  : r_addr[8:3];
    assign w_tag    = w_idle ? bus.cpu_addr[63:9] : r_addr[63:9];
    assign w_we     = w_idle ? bus.cpu_we         : r_we;
    assign w_req    = bus.cpu_req & w_idle & ~rst;
    assign w_victim = w_idle ? w_lru : r_victim;
    assign w_miss   = w_req & (w_hit == '0);

    dcache_tag u_tag (
        .clk      (clk),
        .rst      (rst),
        .i_idx    (w_idx),
        .i_tag    (w_tag),
        .i_req    (w_req),
        .i_vway   (w_victim),
        .i_way    (w_way),
        .i_touch  (w_touch),
        .i_store  (w_we),
        .i_fill   (w_fill),
        .o_hit    (w_hit),
        .o_lru    (w_lru),
        .o_vvalid (w_vvalid),
        .o_vdirty (w_vdirty),
        .o_vtag   (w_vtag)
    );

    // NOTE: every output and strobe gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next            = r_state;
        w_touch           = 1'b0;
        w_fill            = 1'b0;
        w_way             = r_victim;
        bus.cpu_stall     = 1'b0;
        bus.hit           = '0;
        bus.lru           = 1'b0;
        bus.vaild         = 1'b0;
        bus.dirty         = 1'b0;
        bus.write_back    = 1'b0;
        bus.refresh       = 1'b0;
        bus.data_addr     = '0;
        bus.cacheline_new = '0;
        bus.rd_req        = 1'b0;
        bus.rd_addr       = '0;
        bus.wr_req        = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req && w_hit != '0) begin
                        bus.hit       = w_hit;
                        bus.vaild     = 1'b1;
                        bus.data_addr = bus.cpu_addr;
                        w_touch       = 1'b1;
                        w_way         = w_hit[1];
                    end else if (w_req) begin
                        bus.cpu_stall = 1'b1;
                        w_next        = (w_vvalid && w_vdirty) ? ST_WB_READ : ST_REFILL_REQ;
                    end
                end
                ST_WB_READ: begin
                    bus.cpu_stall  = 1'b1;
                    bus.write_back = 1'b1;
                    bus.lru        = r_victim;
                    bus.dirty      = 1'b1;
                    bus.data_addr  = r_addr;
                    w_next         = ST_WB_SEND;
                end
                ST_WB_SEND: begin
                    // The victim line arrives the cycle after write_back; forward it until registered.
                    bus.cpu_stall = 1'b1;
                    bus.wr_req    = 1'b1;
                    bus.wr_addr   = {w_vtag, w_idx, 3'b000};
                    bus.wr_data   = r_wb_first ? bus.cacheline_old : r_wr_data;
                    if (bus.wr_ready) w_next = ST_REFILL_REQ;
                end
                ST_REFILL_REQ: begin
                    bus.cpu_stall = 1'b1;
                    bus.rd_req    = 1'b1;
                    bus.rd_addr   = {r_addr[63:3], 3'b000};
                    if (bus.rd_ready) w_next = ST_REFILL_WAIT;
                end
                ST_REFILL_WAIT: begin
                    bus.cpu_stall = 1'b1;
                    if (bus.rd_valid) w_next = ST_REFILL;
                end
                ST_REFILL: begin
                    bus.cpu_stall     = 1'b1;
                    bus.refresh       = 1'b1;
                    bus.lru           = r_victim;
                    bus.data_addr     = r_addr;
                    bus.cacheline_new = r_line;
                    w_fill            = 1'b1;
                    w_next            = ST_REPLAY;
                end
                ST_REPLAY: begin
                    bus.cpu_stall = 1'b1;
                    bus.hit       = way_onehot(r_victim);
                    bus.vaild     = 1'b1;
                    bus.data_addr = r_addr;
                    w_touch       = 1'b1;
                    w_next        = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_victim   <= 1'b0;
            r_wb_first <= 1'b0;
            r_wr_data  <= '0;
            r_line     <= '0;
        end else begin
            r_state    <= w_next;
            r_wb_first <= (r_state == ST_WB_READ);
            if (w_miss) begin
                r_addr   <= bus.cpu_addr;
                r_we     <= bus.cpu_we;
                r_victim <= w_lru;
            end
            if (r_wb_first) r_wr_data <= bus.cacheline_old;
            if (r_state == ST_REFILL_WAIT && bus.rd_valid) r_line <= bus.rd_data;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, hits, dirty eviction, slow refill, reset mid-write-back.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    localparam logic [63:0] ADDR_A   = 64'h8000_0040;
    localparam logic [63:0] ADDR_B   = 64'h8000_0240;
    localparam logic [63:0] ADDR_C   = 64'h8000_0440;
    localparam logic [63:0] ADDR_D   = 64'h8000_0048;
    localparam logic [63:0] ADDR_E   = 64'h8000_0248;
    localparam logic [63:0] ADDR_F   = 64'h8000_0448;
    localparam logic [63:0] LINE_A   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] LINE_B   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] LINE_C   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] LINE_D   = 64'h5A5A_5A5A_A5A5_A5A5;
    localparam logic [63:0] LINE_E   = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [63:0] JUNK     = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [63:0] OLD_LINE = 64'hCAFE_F00D_0BAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    logic wb_prev = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rdreq;

    dcache_ctrl_if bus ();

    dcache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Data array model: the victim line appears one cycle after write_back, zero otherwise.
    always @(negedge clk) wb_prev = bus.write_back;
    always @(posedge clk) begin
        #1;
        bus.cacheline_old = wb_prev ? OLD_LINE : 64'h0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hit_access(input logic [63:0] addr, input logic we, input logic [1:0] exp_hit);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        #1;
        check("hit_vec",   bus.hit,       exp_hit);
        check("hit_stall", bus.cpu_stall, 0);
        check("hit_vaild", bus.vaild,     1);
        check("hit_daddr", bus.data_addr, addr);
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic miss_start(input logic [63:0] addr, input logic we);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        #1;
        check("miss_stall", bus.cpu_stall, 1);
        check("miss_hit",   bus.hit,       0);
        tick();
    endtask

    // Entered in REFILL_REQ; rd_ready in the first cycle completes the handshake at once.
    task automatic refill(input logic [63:0] addr, input logic [63:0] line, input logic way);
        bus.rd_ready = 1'b1;
        #1;
        check("rd_req",  bus.rd_req,  1);
        check("rd_addr", bus.rd_addr, {addr[63:3], 3'b000});
        tick();
        bus.rd_ready = 1'b0; bus.rd_valid = 1'b1; bus.rd_data = line;
        #1;
        check("wait_rd_req", bus.rd_req, 0);
        tick();
        bus.rd_valid = 1'b0; bus.rd_data = 64'h0;
        #1;
        check("refresh",      bus.refresh,       1);
        check("cl_new",       bus.cacheline_new, line);
        check("refill_lru",   bus.lru,           way);
        check("refill_stall", bus.cpu_stall,     1);
        tick();
        #1;
        check("replay_hit",   bus.hit,       way ? 2'b10 : 2'b01);
        check("replay_vaild", bus.vaild,     1);
        check("replay_daddr", bus.data_addr, addr);
        check("replay_stall", bus.cpu_stall, 1);
        check("replay_rfsh",  bus.refresh,   0);
        tick();
        #1;
        check("post_stall", bus.cpu_stall, 0);
        check("post_hit",   bus.hit,       way ? 2'b10 : 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 64'h0;
        bus.rd_ready = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = 64'h0; bus.wr_ready = 1'b0;
        tick(); tick();
        check("rst_stall",  bus.cpu_stall, 0);
        check("rst_rd_req", bus.rd_req,    0);
        check("rst_wr_req", bus.wr_req,    0);
        check("rst_hit",    bus.hit,       0);
        check("rst_valid",  (dut.u_tag.r_valid == '0), 1);
        rst = 1'b0;
        tick();

        // Cold load miss, refill, replay.
        miss_start(ADDR_A, 1'b0);
        refill(ADDR_A, LINE_A, 1'b0);
        bus.cpu_req = 1'b0;
        tick();

        // Repeat load hits way 0; way 1 becomes next victim.
        hit_access(ADDR_A, 1'b0, 2'b01);
        check("lru8_after_hit", dut.u_tag.r_lru[8], 1);

        // Store marks way 0 dirty; B fills way 1; C must evict dirty way 0.
        hit_access(ADDR_A, 1'b1, 2'b01);
        check("dirty8_w0", dut.u_tag.r_dirty[8][0], 1);
        miss_start(ADDR_B, 1'b0);
        refill(ADDR_B, LINE_B, 1'b1);
        bus.cpu_req = 1'b0;
        tick();
        check("lru8_after_b", dut.u_tag.r_lru[8], 0);

        miss_start(ADDR_C, 1'b0);
        #1;
        check("wbr_write_back", bus.write_back, 1);
        check("wbr_dirty",      bus.dirty,      1);
        check("wbr_lru",        bus.lru,        0);
        check("wbr_daddr",      bus.data_addr,  ADDR_C);
        check("wbr_stall",      bus.cpu_stall,  1);
        tick();
        #1;
        check("wbs_wr_req",  bus.wr_req,     1);
        check("wbs_wr_addr", bus.wr_addr,    ADDR_A);
        check("wbs_wr_data", bus.wr_data,    OLD_LINE);
        check("wbs_wb_pulse", bus.write_back, 0);
        tick();
        bus.wr_ready = 1'b1;
        #1;
        check("wbs_wr_req_hold",  bus.wr_req,  1);
        check("wbs_wr_data_hold", bus.wr_data, OLD_LINE);
        tick();
        bus.wr_ready = 1'b0;
        #1;
        check("wbs_wr_req_drop", bus.wr_req, 0);
        refill(ADDR_C, LINE_C, 1'b0);
        bus.cpu_req = 1'b0;
        tick();

        // Slow memory: rd_ready after 5 cycles, early rd_valid in REFILL_REQ must be ignored.
        miss_start(ADDR_D, 1'b0);
        n_rdreq = 0;
        bus.rd_valid = 1'b1; bus.rd_data = JUNK;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.rd_req) n_rdreq++;
            tick();
            bus.rd_valid = 1'b0; bus.rd_data = 64'h0;
        end
        bus.rd_ready = 1'b1;
        #1;
        if (bus.rd_req) n_rdreq++;
        tick();
        bus.rd_ready = 1'b0;
        check("rd_req_cycles", n_rdreq, 6);
        #1;
        check("slow_wait_rfsh", bus.refresh, 0);
        tick();
        #1;
        check("slow_still_wait", bus.refresh, 0);
        bus.rd_valid = 1'b1; bus.rd_data = LINE_D;
        tick();
        bus.rd_valid = 1'b0; bus.rd_data = 64'h0;
        #1;
        check("slow_refresh", bus.refresh,       1);
        check("slow_cl_new",  bus.cacheline_new, LINE_D);
        tick(); tick();
        #1;
        check("slow_post_stall", bus.cpu_stall, 0);
        check("slow_post_hit",   bus.hit,       2'b01);
        bus.cpu_req = 1'b0;
        tick();

        // Build a dirty victim in set 9, then reset while its write-back is pending.
        hit_access(ADDR_D, 1'b1, 2'b01);
        miss_start(ADDR_E, 1'b0);
        refill(ADDR_E, LINE_E, 1'b1);
        bus.cpu_req = 1'b0;
        tick();
        miss_start(ADDR_F, 1'b0);
        tick();
        #1;
        check("rst_wbs_wr_req",  bus.wr_req,  1);
        check("rst_wbs_wr_addr", bus.wr_addr, ADDR_D);
        rst = 1'b1;
        #1;
        check("rst_mid_wr_req", bus.wr_req,    0);
        check("rst_mid_stall",  bus.cpu_stall, 0);
        check("rst_mid_valid",  (dut.u_tag.r_valid == '0), 1);
        tick();
        rst = 1'b0;
        bus.cpu_addr = ADDR_A;
        #1;
        check("post_rst_stall", bus.cpu_stall, 1);
        check("post_rst_hit",   bus.hit,       0);
        tick();
        #1;
        check("post_rst_rd_req", bus.rd_req, 1);
        check("post_rst_wr_req", bus.wr_req, 0);
        bus.cpu_req = 1'b0;
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
